// File: rtl/fifo_param_pkg.sv
// Shared defaults and constant helpers for the parameterised FIFO.
package fifo_param_pkg;

  localparam int unsigned DEF_DATA_SIZE = 8;
  localparam int unsigned DEF_DEPTH     = 8;

  // Bits needed to encode values 0..value-1 (minimum 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem_ram.sv
// FIFO storage: DEPTH x DATA_SIZE register array, one write port, registered read port.
module fifo_mem_ram #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Array is intentionally not reset; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with runtime thresholds, hysteretic pause and sticky error.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter  int unsigned DATA_SIZE = DEF_DATA_SIZE,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  localparam int unsigned PTR_W     = clog2(DEPTH),
  localparam int unsigned CNT_W     = clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in_push,
  input  logic [CNT_W-1:0]     thr_full,
  input  logic [CNT_W-1:0]     thr_empty,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out_pop,
  output logic                 valid_out,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_pause,
  output logic                 fifo_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             rd_ok, wr_ok, err_set, err_nxt, pause_nxt;

  // Acceptance: a read frees a slot for a same-edge write; no empty bypass.
  always_comb begin
    rd_ok      = read && (count != '0);
    wr_ok      = write && ((count < CNT_MAX) || rd_ok);
    err_set    = (write && !wr_ok) || (read && !rd_ok);
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_ok) wr_ptr_nxt = (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PTR_W'(1);
    if (rd_ok) rd_ptr_nxt = (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PTR_W'(1);
    if (wr_ok && !rd_ok)      count_nxt = count + CNT_W'(1);
    else if (rd_ok && !wr_ok) count_nxt = count - CNT_W'(1);
    err_nxt = err_set || (fifo_error && !err_clr);
    if (count_nxt >= thr_full)       pause_nxt = 1'b1;
    else if (count_nxt <= thr_empty) pause_nxt = 1'b0;
    else                             pause_nxt = fifo_pause;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_out  <= 1'b0;
      fifo_error <= 1'b0;
      fifo_pause <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      valid_out  <= rd_ok;
      fifo_error <= err_nxt;
      fifo_pause <= pause_nxt;
    end
  end

  fifo_mem_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_W    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in_push),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out_pop)
  );

  assign fifo_count   = count;
  assign fifo_full    = (count == CNT_MAX);
  assign fifo_empty   = (count == '0);
  assign almost_full  = (count >= thr_full);
  assign almost_empty = (count <= thr_empty);

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus random traffic vs a queue model.
module tb_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write = 1'b0, read = 1'b0, err_clr = 1'b0;
  logic [DW-1:0] data_in_push = '0;
  logic [CW-1:0] thr_full = CW'(6), thr_empty = CW'(2);
  logic [DW-1:0] data_out_pop;
  logic [CW-1:0] fifo_count;
  logic          valid_out, fifo_full, fifo_empty, almost_full, almost_empty;
  logic          fifo_pause, fifo_error;

  fifo_param #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .data_in_push (data_in_push),
    .thr_full     (thr_full),
    .thr_empty    (thr_empty),
    .err_clr      (err_clr),
    .data_out_pop (data_out_pop),
    .valid_out    (valid_out),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_pause   (fifo_pause),
    .fifo_error   (fifo_error)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout  = '0;
  bit            m_valid = 1'b0;
  bit            m_err   = 1'b0;
  bit            m_pause = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = q.size();
    check({tag, ".count"},  32'(fifo_count),   32'(n));
    check({tag, ".valid"},  32'(valid_out),    32'(m_valid));
    if (m_valid) check({tag, ".data"}, 32'(data_out_pop), 32'(m_dout));
    else         check({tag, ".hold"}, 32'(data_out_pop), 32'(m_dout));
    check({tag, ".full"},   32'(fifo_full),    32'(n == DEPTH));
    check({tag, ".empty"},  32'(fifo_empty),   32'(n == 0));
    check({tag, ".afull"},  32'(almost_full),  32'(n >= int'(thr_full)));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= int'(thr_empty)));
    check({tag, ".pause"},  32'(fifo_pause),   32'(m_pause));
    check({tag, ".error"},  32'(fifo_error),   32'(m_err));
  endtask

  // One clock: apply inputs, advance model at the edge, compare 1ns later.
  task automatic cycle(input string tag, input bit w, input bit r,
                       input logic [DW-1:0] d, input bit clr);
    bit rd_ok, wr_ok;
    int unsigned n;
    write = w; read = r; data_in_push = d; err_clr = clr;
    @(posedge clk);
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEPTH) || rd_ok);
    m_valid = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    if ((w && !wr_ok) || (r && !rd_ok)) m_err = 1'b1;
    else if (clr)                       m_err = 1'b0;
    n = q.size();
    if (n >= int'(thr_full))       m_pause = 1'b1;
    else if (n <= int'(thr_empty)) m_pause = 1'b0;
    #1;
    check_all(tag);
    write = 1'b0; read = 1'b0; err_clr = 1'b0;
  endtask

  // Asynchronous reset asserted and released away from clock edges.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #2;
    q.delete();
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0; m_pause = 1'b0;
    check_all({tag, ".nocLk"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) cycle("fill", 1, 0, DW'(i), 0);
    cycle("overflow", 1, 0, 8'hFF, 0);
    for (int i = 0; i < 8; i++) cycle("drain", 0, 1, '0, 0);
    cycle("idle_hold", 0, 0, '0, 0);

    // Pointer wrap
    for (int i = 0; i < 5; i++) cycle("wrap_w5", 1, 0, DW'(8'h50 + i), 1);
    for (int i = 0; i < 5; i++) cycle("wrap_r5", 0, 1, '0, 0);
    for (int i = 0; i < 6; i++) cycle("wrap_w6", 1, 0, DW'(8'hA0 + i), 0);
    for (int i = 0; i < 6; i++) cycle("wrap_r6", 0, 1, '0, 0);

    // Threshold hysteresis
    thr_full = CW'(6); thr_empty = CW'(2);
    for (int i = 0; i < 6; i++) cycle("thr_fill", 1, 0, DW'(8'h30 + i), 0);
    for (int i = 0; i < 4; i++) cycle("thr_drain", 0, 1, '0, 0);

    // Full and empty with simultaneous read and write
    for (int i = 0; i < 6; i++) cycle("fill_full", 1, 0, DW'(8'hC0 + i), 0);
    cycle("full_rw", 1, 1, 8'hCC, 0);
    for (int i = 0; i < 8; i++) cycle("drain_all", 0, 1, '0, 0);
    cycle("empty_rw", 1, 1, 8'hEE, 0);
    cycle("pop_last", 0, 1, '0, 0);

    // Error clear rules
    cycle("err_clr", 0, 0, '0, 1);
    cycle("err_set", 0, 1, '0, 0);
    cycle("err_clr_vs_set", 0, 1, '0, 1);
    cycle("err_clr2", 0, 0, '0, 1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1, 0, DW'(8'h70 + i), 0);
    async_reset("mid_rst");
    cycle("post_rst_read", 0, 1, '0, 0);

    // Random traffic with occasional threshold changes and resets
    for (int k = 0; k < 3000; k++) begin
      bit w, r, c;
      if ($urandom_range(0, 99) < 3) begin
        int unsigned tf;
        tf = $urandom_range(1, DEPTH);
        thr_full  = CW'(tf);
        thr_empty = CW'($urandom_range(0, tf - 1));
      end
      if ($urandom_range(0, 999) < 3) async_reset("rnd_rst");
      w = ($urandom_range(0, 99) < ((k / 300) % 2 == 0 ? 65 : 35));
      r = ($urandom_range(0, 99) < ((k / 300) % 2 == 0 ? 35 : 65));
      c = ($urandom_range(0, 99) < 10);
      cycle("rnd", w, r, DW'($urandom), c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
